// File: rtl/cva6_id_remap_table.sv
// cva6_id_remap_table: compresses wide AXI IDs onto a small per-direction
// table of master-side IDs. Each entry counts its outstanding transactions,
// so ordering per original ID is kept while the table is shared.
// Only IDs and handshakes pass through here; payloads travel alongside.

// One direction's remap table (request lookup, response restore, counters).
module cva6_id_remap_dir #(
    parameter int unsigned SlvIdWidth   = 7,
    parameter int unsigned MstIdWidth   = 5,
    parameter int unsigned MaxUniqIds   = 4,
    parameter int unsigned MaxTxnsPerId = 2,
    parameter int unsigned CntW         = $clog2(MaxTxnsPerId + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    // request side
    input  logic                  req_valid_i,
    input  logic [SlvIdWidth-1:0] req_id_i,
    input  logic                  req_ready_i,
    output logic                  req_valid_o,
    output logic                  req_ready_o,
    output logic [MstIdWidth-1:0] req_id_o,
    // response side
    input  logic                  rsp_hs_i,
    input  logic                  rsp_dec_i,
    input  logic [MstIdWidth-1:0] rsp_id_i,
    output logic [SlvIdWidth-1:0] rsp_id_o,
    // status
    output logic                  busy_o,
    output logic                  unmapped_o
);

    localparam int unsigned     IdxW   = (MaxUniqIds > 1) ? $clog2(MaxUniqIds) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(MaxTxnsPerId);

    logic [MaxUniqIds-1:0][SlvIdWidth-1:0] orig_vec;
    logic [MaxUniqIds-1:0][CntW-1:0]       cnt_vec;
    logic [MaxUniqIds-1:0]                 vld;

    logic            hit, hit_full, free_found, grant, req_hs, rsp_mapped;
    logic [IdxW-1:0] hit_idx, free_idx, gnt_idx;

    // Request lookup: reuse the entry already holding this ID, else the
    // lowest free one. Never open a second entry for a live ID.
    always_comb begin
        hit        = 1'b0;
        hit_full   = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < int'(MaxUniqIds); i++) begin
            if (vld[i] && (orig_vec[i] == req_id_i)) begin
                hit      = 1'b1;
                hit_full = (cnt_vec[i] == CntMax);
                hit_idx  = IdxW'(i);
            end
        end
        for (int i = int'(MaxUniqIds) - 1; i >= 0; i--) begin
            if (!vld[i]) begin
                free_found = 1'b1;
                free_idx   = IdxW'(i);
            end
        end
    end

    // grant depends only on table state and the request ID, never on valid,
    // so ready has no path from valid.
    assign grant       = hit ? !hit_full : free_found;
    assign gnt_idx     = hit ? hit_idx : free_idx;
    assign req_valid_o = req_valid_i & grant;
    assign req_ready_o = req_ready_i & grant;
    assign req_id_o    = MstIdWidth'(gnt_idx);
    assign req_hs      = req_valid_i & req_ready_i & grant;

    // Response restore: unmapped IDs come back as 0 and are flagged.
    always_comb begin
        rsp_mapped = 1'b0;
        rsp_id_o   = '0;
        for (int i = 0; i < int'(MaxUniqIds); i++) begin
            if (vld[i] && (rsp_id_i == MstIdWidth'(i))) begin
                rsp_mapped = 1'b1;
                rsp_id_o   = orig_vec[i];
            end
        end
    end

    assign unmapped_o = rsp_hs_i & !rsp_mapped;
    assign busy_o     = |vld;

    for (genvar g = 0; g < int'(MaxUniqIds); g++) begin : g_entry
        logic [SlvIdWidth-1:0] orig_q, orig_d;
        logic [CntW-1:0]       cnt_q, cnt_d;
        logic                  inc, dec;

        assign vld[g]      = (cnt_q != '0);
        assign orig_vec[g] = orig_q;
        assign cnt_vec[g]  = cnt_q;
        assign inc = req_hs && (gnt_idx == IdxW'(g));
        assign dec = rsp_hs_i && rsp_dec_i && vld[g] && (rsp_id_i == MstIdWidth'(g));

        // Next count: an issue and a retire in the same cycle cancel out.
        always_comb begin
            cnt_d  = cnt_q;
            orig_d = orig_q;
            if (inc && !dec) begin
                cnt_d = cnt_q + CntW'(1);
            end else if (dec && !inc) begin
                cnt_d = cnt_q - CntW'(1);
            end
            if (inc) begin
                orig_d = req_id_i;
            end
        end

        // Entry state register.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q  <= '0;
                orig_q <= '0;
            end else begin
                cnt_q  <= cnt_d;
                orig_q <= orig_d;
            end
        end
    end

endmodule

module cva6_id_remap_table #(
    parameter int unsigned SlvIdWidth   = 7,
    parameter int unsigned MstIdWidth   = 5,
    parameter int unsigned MaxUniqIds   = 4,
    parameter int unsigned MaxTxnsPerId = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    // AW
    input  logic                  slv_aw_valid_i,
    output logic                  slv_aw_ready_o,
    input  logic [SlvIdWidth-1:0] slv_aw_id_i,
    output logic                  mst_aw_valid_o,
    input  logic                  mst_aw_ready_i,
    output logic [MstIdWidth-1:0] mst_aw_id_o,
    // AR
    input  logic                  slv_ar_valid_i,
    output logic                  slv_ar_ready_o,
    input  logic [SlvIdWidth-1:0] slv_ar_id_i,
    output logic                  mst_ar_valid_o,
    input  logic                  mst_ar_ready_i,
    output logic [MstIdWidth-1:0] mst_ar_id_o,
    // B
    input  logic                  mst_b_valid_i,
    output logic                  mst_b_ready_o,
    input  logic [MstIdWidth-1:0] mst_b_id_i,
    output logic                  slv_b_valid_o,
    input  logic                  slv_b_ready_i,
    output logic [SlvIdWidth-1:0] slv_b_id_o,
    // R
    input  logic                  mst_r_valid_i,
    output logic                  mst_r_ready_o,
    input  logic [MstIdWidth-1:0] mst_r_id_i,
    input  logic                  mst_r_last_i,
    output logic                  slv_r_valid_o,
    input  logic                  slv_r_ready_i,
    output logic [SlvIdWidth-1:0] slv_r_id_o,
    output logic                  slv_r_last_o,
    // status
    output logic                  wr_busy_o,
    output logic                  rd_busy_o,
    output logic                  err_o
);

    if (MstIdWidth > SlvIdWidth) begin : g_chk_width
        $error("MstIdWidth must not exceed SlvIdWidth");
    end
    if ((MaxUniqIds < 1) || (MaxUniqIds > (2 ** MstIdWidth))) begin : g_chk_ids
        $error("MaxUniqIds must be in 1 .. 2**MstIdWidth");
    end
    if (MaxTxnsPerId < 1) begin : g_chk_txns
        $error("MaxTxnsPerId must be at least 1");
    end

    logic b_hs, r_hs, b_unmapped, r_unmapped, err_q;

    assign b_hs = mst_b_valid_i & slv_b_ready_i;
    assign r_hs = mst_r_valid_i & slv_r_ready_i;

    // Responses are pure pass-through apart from the restored ID.
    assign slv_b_valid_o = mst_b_valid_i;
    assign mst_b_ready_o = slv_b_ready_i;
    assign slv_r_valid_o = mst_r_valid_i;
    assign mst_r_ready_o = slv_r_ready_i;
    assign slv_r_last_o  = mst_r_last_i;

    // Write table: AW allocates, B retires (no ATOP support, so AW never
    // touches the read table).
    cva6_id_remap_dir #(
        .SlvIdWidth  (SlvIdWidth),
        .MstIdWidth  (MstIdWidth),
        .MaxUniqIds  (MaxUniqIds),
        .MaxTxnsPerId(MaxTxnsPerId)
    ) u_wr (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_valid_i(slv_aw_valid_i),
        .req_id_i   (slv_aw_id_i),
        .req_ready_i(mst_aw_ready_i),
        .req_valid_o(mst_aw_valid_o),
        .req_ready_o(slv_aw_ready_o),
        .req_id_o   (mst_aw_id_o),
        .rsp_hs_i   (b_hs),
        .rsp_dec_i  (1'b1),
        .rsp_id_i   (mst_b_id_i),
        .rsp_id_o   (slv_b_id_o),
        .busy_o     (wr_busy_o),
        .unmapped_o (b_unmapped)
    );

    // Read table: AR allocates, the last R beat retires.
    cva6_id_remap_dir #(
        .SlvIdWidth  (SlvIdWidth),
        .MstIdWidth  (MstIdWidth),
        .MaxUniqIds  (MaxUniqIds),
        .MaxTxnsPerId(MaxTxnsPerId)
    ) u_rd (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_valid_i(slv_ar_valid_i),
        .req_id_i   (slv_ar_id_i),
        .req_ready_i(mst_ar_ready_i),
        .req_valid_o(mst_ar_valid_o),
        .req_ready_o(slv_ar_ready_o),
        .req_id_o   (mst_ar_id_o),
        .rsp_hs_i   (r_hs),
        .rsp_dec_i  (mst_r_last_i),
        .rsp_id_i   (mst_r_id_i),
        .rsp_id_o   (slv_r_id_o),
        .busy_o     (rd_busy_o),
        .unmapped_o (r_unmapped)
    );

    // Sticky error: any response handshake carrying an unmapped ID.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (b_unmapped || r_unmapped) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_cva6_id_remap_table.sv
// Bench for cva6_id_remap_table: directed scenarios with literal checks,
// then random traffic, all compared every cycle against a table model.
module tb_cva6_id_remap_table;
    localparam int SW = 7;
    localparam int MW = 5;
    localparam int NU = 4;
    localparam int MT = 2;

    logic clk, rst_ni;
    logic slv_aw_valid_i, slv_aw_ready_o, mst_aw_valid_o, mst_aw_ready_i;
    logic [SW-1:0] slv_aw_id_i;
    logic [MW-1:0] mst_aw_id_o;
    logic slv_ar_valid_i, slv_ar_ready_o, mst_ar_valid_o, mst_ar_ready_i;
    logic [SW-1:0] slv_ar_id_i;
    logic [MW-1:0] mst_ar_id_o;
    logic mst_b_valid_i, mst_b_ready_o, slv_b_valid_o, slv_b_ready_i;
    logic [MW-1:0] mst_b_id_i;
    logic [SW-1:0] slv_b_id_o;
    logic mst_r_valid_i, mst_r_ready_o, mst_r_last_i, slv_r_valid_o, slv_r_ready_i, slv_r_last_o;
    logic [MW-1:0] mst_r_id_i;
    logic [SW-1:0] slv_r_id_o;
    logic wr_busy_o, rd_busy_o, err_o;

    cva6_id_remap_table #(
        .SlvIdWidth(SW), .MstIdWidth(MW), .MaxUniqIds(NU), .MaxTxnsPerId(MT)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .slv_aw_valid_i(slv_aw_valid_i), .slv_aw_ready_o(slv_aw_ready_o), .slv_aw_id_i(slv_aw_id_i),
        .mst_aw_valid_o(mst_aw_valid_o), .mst_aw_ready_i(mst_aw_ready_i), .mst_aw_id_o(mst_aw_id_o),
        .slv_ar_valid_i(slv_ar_valid_i), .slv_ar_ready_o(slv_ar_ready_o), .slv_ar_id_i(slv_ar_id_i),
        .mst_ar_valid_o(mst_ar_valid_o), .mst_ar_ready_i(mst_ar_ready_i), .mst_ar_id_o(mst_ar_id_o),
        .mst_b_valid_i(mst_b_valid_i), .mst_b_ready_o(mst_b_ready_o), .mst_b_id_i(mst_b_id_i),
        .slv_b_valid_o(slv_b_valid_o), .slv_b_ready_i(slv_b_ready_i), .slv_b_id_o(slv_b_id_o),
        .mst_r_valid_i(mst_r_valid_i), .mst_r_ready_o(mst_r_ready_o), .mst_r_id_i(mst_r_id_i),
        .mst_r_last_i(mst_r_last_i), .slv_r_valid_o(slv_r_valid_o), .slv_r_ready_i(slv_r_ready_i),
        .slv_r_id_o(slv_r_id_o), .slv_r_last_o(slv_r_last_o),
        .wr_busy_o(wr_busy_o), .rd_busy_o(rd_busy_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: outstanding count and original ID per entry, per direction.
    int w_cnt[NU], w_orig[NU], r_cnt[NU], r_orig[NU];
    bit m_err;
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < NU; i++) begin
            w_cnt[i] = 0; w_orig[i] = 0; r_cnt[i] = 0; r_orig[i] = 0;
        end
        m_err = 1'b0;
    endfunction

    // Which entry may a request with this ID use, if any.
    function automatic void lookup(input bit rd, input int id, output bit g, output int idx);
        int c[NU];
        int o[NU];
        for (int i = 0; i < NU; i++) begin
            c[i] = rd ? r_cnt[i] : w_cnt[i];
            o[i] = rd ? r_orig[i] : w_orig[i];
        end
        g = 1'b0;
        idx = 0;
        for (int i = 0; i < NU; i++)
            if (c[i] != 0 && o[i] == id) begin g = (c[i] < MT); idx = i; return; end
        for (int i = 0; i < NU; i++)
            if (c[i] == 0) begin g = 1'b1; idx = i; return; end
    endfunction

    function automatic void rsp(input bit rd, input int id, output bit m, output int o);
        m = 1'b0;
        o = 0;
        if (id < NU) begin
            if ((rd ? r_cnt[id] : w_cnt[id]) != 0) begin
                m = 1'b1;
                o = rd ? r_orig[id] : w_orig[id];
            end
        end
    endfunction

    function automatic bit busy(input bit rd);
        for (int i = 0; i < NU; i++)
            if ((rd ? r_cnt[i] : w_cnt[i]) != 0) return 1'b1;
        return 1'b0;
    endfunction

    // One cycle: called at posedge+2 with inputs set; checks every output
    // against the model, then advances the model at the clock edge.
    task automatic step();
        bit wg, rg, bm, rm, aw_hs, ar_hs, b_hs, r_hs, last;
        int wi, ri, bo, ro, bid, rid;
        logic [SW-1:0] awid, arid;
        #1;
        lookup(1'b0, int'(slv_aw_id_i), wg, wi);
        lookup(1'b1, int'(slv_ar_id_i), rg, ri);
        bid = int'(mst_b_id_i);
        rid = int'(mst_r_id_i);
        rsp(1'b0, bid, bm, bo);
        rsp(1'b1, rid, rm, ro);
        chk("aw_valid", mst_aw_valid_o, slv_aw_valid_i & wg);
        chk("aw_ready", slv_aw_ready_o, mst_aw_ready_i & wg);
        if (wg) chk("aw_id", mst_aw_id_o, wi);
        chk("ar_valid", mst_ar_valid_o, slv_ar_valid_i & rg);
        chk("ar_ready", slv_ar_ready_o, mst_ar_ready_i & rg);
        if (rg) chk("ar_id", mst_ar_id_o, ri);
        chk("b_valid", slv_b_valid_o, mst_b_valid_i);
        chk("b_ready", mst_b_ready_o, slv_b_ready_i);
        chk("b_id", slv_b_id_o, bm ? bo : 0);
        chk("r_valid", slv_r_valid_o, mst_r_valid_i);
        chk("r_ready", mst_r_ready_o, slv_r_ready_i);
        chk("r_last", slv_r_last_o, mst_r_last_i);
        chk("r_id", slv_r_id_o, rm ? ro : 0);
        chk("wr_busy", wr_busy_o, busy(1'b0));
        chk("rd_busy", rd_busy_o, busy(1'b1));
        chk("err", err_o, m_err);
        aw_hs = slv_aw_valid_i & mst_aw_ready_i & wg;
        ar_hs = slv_ar_valid_i & mst_ar_ready_i & rg;
        b_hs  = mst_b_valid_i & slv_b_ready_i;
        r_hs  = mst_r_valid_i & slv_r_ready_i;
        last  = mst_r_last_i;
        awid  = slv_aw_id_i;
        arid  = slv_ar_id_i;
        @(posedge clk);
        if (rst_ni) begin
            if (aw_hs) begin w_cnt[wi]++; w_orig[wi] = int'(awid); end
            if (b_hs && bm) w_cnt[bid]--;
            if (ar_hs) begin r_cnt[ri]++; r_orig[ri] = int'(arid); end
            if (r_hs && rm && last) r_cnt[rid]--;
            if ((b_hs && !bm) || (r_hs && !rm)) m_err = 1'b1;
        end
        #2;
    endtask

    task automatic idle();
        slv_aw_valid_i = 0; slv_aw_id_i = '0; mst_aw_ready_i = 1;
        slv_ar_valid_i = 0; slv_ar_id_i = '0; mst_ar_ready_i = 1;
        mst_b_valid_i = 0; mst_b_id_i = '0; slv_b_ready_i = 1;
        mst_r_valid_i = 0; mst_r_id_i = '0; mst_r_last_i = 0; slv_r_ready_i = 1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        model_clear();
        idle();
        step();
        step();
        rst_ni = 1'b1;
    endtask

    function automatic logic [SW-1:0] pick_id();
        case ($urandom_range(0, 5))
            0: return 7'h00;
            1: return 7'h12;
            2: return 7'h33;
            3: return 7'h45;
            4: return 7'h7F;
            default: return 7'($urandom_range(0, 127));
        endcase
    endfunction

    function automatic logic [MW-1:0] pick_rsp();
        if ($urandom_range(0, 15) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, NU - 1));
    endfunction

    initial begin
        rst_ni = 1'b0;
        idle();
        model_clear();
        @(posedge clk);
        #2;
        // Reset state, including combinational pass-through on an empty table.
        slv_ar_valid_i = 1;
        slv_ar_id_i = 7'h45;
        #1;
        chk("rst_err", err_o, 0);
        chk("rst_wr_busy", wr_busy_o, 0);
        chk("rst_rd_busy", rd_busy_o, 0);
        chk("rst_ar_valid", mst_ar_valid_o, 1);
        chk("rst_ar_id", mst_ar_id_o, 0);
        step();
        step();
        rst_ni = 1'b1;

        // First AR after reset.
        #1;
        chk("t1_ar_id", mst_ar_id_o, 0);
        chk("t1_ar_hs", slv_ar_ready_o & mst_ar_valid_o, 1);
        step();
        idle();
        #1 chk("t1_rd_busy", rd_busy_o, 1);
        step();

        // Same-ID limit.
        do_reset();
        slv_ar_valid_i = 1; slv_ar_id_i = 7'h12;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("t2_id", mst_ar_id_o, 0);
            chk("t2_rdy", slv_ar_ready_o, 1);
            step();
        end
        mst_r_valid_i = 1; mst_r_id_i = 0; mst_r_last_i = 1;
        #1 chk("t2_stall", slv_ar_ready_o, 0);
        step();
        mst_r_valid_i = 0; mst_r_last_i = 0;
        #1;
        chk("t2_reissue", slv_ar_ready_o, 1);
        chk("t2_reissue_id", mst_ar_id_o, 0);
        step();
        idle();
        step();

        // Table full, then a freed entry is reused.
        do_reset();
        slv_aw_valid_i = 1;
        for (int k = 1; k <= 4; k++) begin
            slv_aw_id_i = 7'(k);
            #1 chk("t3_id", mst_aw_id_o, k - 1);
            step();
        end
        slv_aw_id_i = 7'h05;
        #1 chk("t3_full", slv_aw_ready_o, 0);
        mst_b_valid_i = 1; mst_b_id_i = 5'd2;
        #1 chk("t3_b_id", slv_b_id_o, 7'h03);
        step();
        mst_b_valid_i = 0;
        #1;
        chk("t3_reuse_rdy", slv_aw_ready_o, 1);
        chk("t3_reuse_id", mst_aw_id_o, 2);
        step();
        idle();
        step();

        // Restore path across a three-beat burst.
        do_reset();
        slv_ar_valid_i = 1; slv_ar_id_i = 7'h7F;
        step();
        idle();
        mst_r_valid_i = 1; mst_r_id_i = 0;
        for (int b = 0; b < 3; b++) begin
            mst_r_last_i = (b == 2);
            #1;
            chk("t4_r_id", slv_r_id_o, 7'h7F);
            chk("t4_busy", rd_busy_o, 1);
            step();
        end
        idle();
        #1 chk("t4_busy_off", rd_busy_o, 0);
        step();

        // Issue and retire on the same entry in one cycle.
        do_reset();
        slv_ar_valid_i = 1; slv_ar_id_i = 7'h10;
        step();
        slv_ar_id_i = 7'h33;
        #1 chk("t5_idx1", mst_ar_id_o, 1);
        step();
        mst_r_valid_i = 1; mst_r_id_i = 5'd1; mst_r_last_i = 1;
        #1;
        chk("t5_same_rdy", slv_ar_ready_o, 1);
        chk("t5_same_id", mst_ar_id_o, 1);
        step();
        mst_r_valid_i = 0; mst_r_last_i = 0;
        #1 chk("t5_cnt1_rdy", slv_ar_ready_o, 1);
        step();
        #1 chk("t5_cnt2_stall", slv_ar_ready_o, 0);
        idle();
        step();

        // Unmapped B response.
        do_reset();
        slv_aw_valid_i = 1; slv_aw_id_i = 7'h21;
        step();
        idle();
        mst_b_valid_i = 1; mst_b_id_i = 5'd3;
        #1;
        chk("t6_b_id", slv_b_id_o, 0);
        chk("t6_err_pre", err_o, 0);
        step();
        idle();
        #1;
        chk("t6_err", err_o, 1);
        chk("t6_wr_busy", wr_busy_o, 1);
        step();
        step();
        slv_aw_valid_i = 1; slv_aw_id_i = 7'h21;
        #1;
        chk("t6_err_held", err_o, 1);
        chk("t6_cnt_rdy", slv_aw_ready_o, 1);
        chk("t6_cnt_id", mst_aw_id_o, 0);
        step();
        #1 chk("t6_cnt_stall", slv_aw_ready_o, 0);
        idle();
        step();

        // Random traffic with occasional mid-run reset.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            slv_aw_valid_i = ($urandom_range(0, 9) < 7);
            slv_aw_id_i    = pick_id();
            mst_aw_ready_i = ($urandom_range(0, 3) != 0);
            slv_ar_valid_i = ($urandom_range(0, 9) < 7);
            slv_ar_id_i    = pick_id();
            mst_ar_ready_i = ($urandom_range(0, 3) != 0);
            mst_b_valid_i  = ($urandom_range(0, 1) == 1);
            mst_b_id_i     = pick_rsp();
            slv_b_ready_i  = ($urandom_range(0, 3) != 0);
            mst_r_valid_i  = ($urandom_range(0, 1) == 1);
            mst_r_id_i     = pick_rsp();
            mst_r_last_i   = ($urandom_range(0, 1) == 1);
            slv_r_ready_i  = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
